// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//   Responder for the processor dmem port. Word RAM in the low part of the
//   map plus a small MMIO window at the top: cycle counter (0xFF0), LED
//   register (0xFF1), TX FIFO push (0xFF2) and FIFO status (0xFF3).
//   Read data is registered: q reflects the address sampled one edge earlier.
//
// Optional feature macro: MMIO_CYCLE_COUNTER_EN
//   Defined   - 32-bit free-running cycle counter readable at 0xFF0.
//   Undefined - no counter flops; 0xFF0 reads 0 like unmapped space.
//
// Ports:
//   clock     in   single clock, rising edge
//   reset     in   synchronous, active-low
//   address   in   12-bit word address
//   data      in   32-bit write data
//   wren      in   write enable
//   q         out  registered read data
//   led_out   out  LED register
//   tx_data   out  FIFO head byte (0 when empty)
//   tx_valid  out  FIFO non-empty
//   tx_ready  in   consumer takes the head byte this cycle
module dmem_mmio_responder #(
    parameter int unsigned RAM_DEPTH  = 1024,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LED_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [11:0]      address,
    input  logic [31:0]      data,
    input  logic             wren,
    output logic [31:0]      q,
    output logic [LED_W-1:0] led_out,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    localparam logic [11:0] ADDR_CYCLE  = 12'hFF0;
    localparam logic [11:0] ADDR_LED    = 12'hFF1;
    localparam logic [11:0] ADDR_TXPUSH = 12'hFF2;
    localparam logic [11:0] ADDR_STATUS = 12'hFF3;

    logic [31:0]      mem [RAM_DEPTH];
    logic [7:0]       fifo_mem [FIFO_DEPTH];

    logic [31:0]      q_q, q_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             in_ram;
    logic             fifo_empty, fifo_full;
    logic             push, pop, do_push;
    logic             ovf_set, ovf_clr;
    logic [31:0]      cyc_rd;

    assign in_ram     = {1'b0, address} < 13'(RAM_DEPTH);
    assign fifo_empty = (count_q == 5'd0);
    assign fifo_full  = (count_q == 5'(FIFO_DEPTH));

    assign push    = wren && (address == ADDR_TXPUSH);
    assign pop     = tx_valid && tx_ready;
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign do_push = push && (!fifo_full || pop);
    assign ovf_set = push && fifo_full && !pop;
    assign ovf_clr = wren && (address == ADDR_STATUS) && data[2];

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cyc_rd = cyc_q;
`else
    assign cyc_rd = '0;
`endif

    always_comb begin
        q_d      = '0;
        led_d    = led_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        // Read mux uses pre-edge state, so same-cycle writes/pushes/pops
        // are not visible until the next access.
        if (in_ram) begin
            q_d = mem[address[AW-1:0]];
        end else if (address == ADDR_CYCLE) begin
            q_d = cyc_rd;
        end else if (address == ADDR_LED) begin
            q_d = 32'(led_q);
        end else if (address == ADDR_STATUS) begin
            q_d = {23'd0, count_q, 1'b0, ovf_q, fifo_full, fifo_empty};
        end

        if (wren && (address == ADDR_LED)) begin
            led_d = data[LED_W-1:0];
        end

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({do_push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            q_q      <= '0;
            led_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            q_q      <= q_d;
            led_q    <= led_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage arrays carry no reset; contents are only gated off writes
    // while reset is held.
    always_ff @(posedge clock) begin
        if (reset && wren && in_ram) begin
            mem[address[AW-1:0]] <= data;
        end
        if (reset && do_push) begin
            fifo_mem[wr_ptr_q] <= data[7:0];
        end
    end

    assign q        = q_q;
    assign led_out  = led_q;
    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'd0 : fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

    localparam int unsigned RAM_DEPTH  = 1024;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LED_W      = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [11:0]      address = '0;
    logic [31:0]      data = '0;
    logic             wren = 1'b0;
    logic [31:0]      q;
    logic [LED_W-1:0] led_out;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_mmio_responder #(
        .RAM_DEPTH (RAM_DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .LED_W     (LED_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .wren    (wren),
        .q       (q),
        .led_out (led_out),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [31:0]      mref [RAM_DEPTH];
    logic [LED_W-1:0] led_m = '0;
    logic [7:0]       fifo_m [$];
    logic             ovf_m = 1'b0;
    logic [31:0]      cyc_m = '0;
    logic [31:0]      exp_q = '0;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int unsigned n;
        n = fifo_m.size();
        if (int'(a) < int'(RAM_DEPTH)) return mref[a];
`ifdef MMIO_CYCLE_COUNTER_EN
        if (a == 12'hFF0) return cyc_m;
`endif
        if (a == 12'hFF1) return 32'(led_m);
        if (a == 12'hFF3)
            return (32'(n) << 4) | (32'(ovf_m) << 2)
                 | (32'(n == FIFO_DEPTH) << 1) | 32'(n == 0);
        return 32'd0;
    endfunction

    function automatic logic exp_valid();
        return fifo_m.size() != 0;
    endfunction

    function automatic logic [7:0] exp_head();
        return (fifo_m.size() != 0) ? fifo_m[0] : 8'd0;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic step(input logic rst, input logic [11:0] a, input logic [31:0] d,
                        input logic we, input logic rdy);
        logic was_full, popped, set_o;
        reset = rst; address = a; data = d; wren = we; tx_ready = rdy;
        @(posedge clock);
        if (!rst) begin
            exp_q = '0; led_m = '0; fifo_m.delete(); ovf_m = 1'b0; cyc_m = '0;
        end else begin
            exp_q    = model_read(a);
            was_full = (fifo_m.size() == FIFO_DEPTH);
            popped   = rdy && (fifo_m.size() != 0);
            set_o    = 1'b0;
            if (popped) void'(fifo_m.pop_front());
            if (we && a == 12'hFF2) begin
                if (was_full && !popped) set_o = 1'b1;
                else fifo_m.push_back(d[7:0]);
            end
            if (set_o) ovf_m = 1'b1;
            else if (we && a == 12'hFF3 && d[2]) ovf_m = 1'b0;
            if (we && a == 12'hFF1) led_m = d[LED_W-1:0];
            if (we && int'(a) < int'(RAM_DEPTH)) mref[a] = d;
            cyc_m = cyc_m + 32'd1;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // push and LED write presented while reset is low must be ignored
        step(1'b0, 12'hFF2, 32'h77, 1'b1, 1'b1);
        n_tests++; if (q !== 32'd0) begin n_fail++; $display("FAIL reset_q got %h want %h", q, 32'd0); end
        n_tests++; if (led_out !== '0) begin n_fail++; $display("FAIL reset_led got %h want 0", led_out); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", tx_valid); end
        n_tests++; if (tx_data !== 8'd0) begin n_fail++; $display("FAIL reset_txdata got %h want 00", tx_data); end
        step(1'b1, 12'hFF3, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'h1) begin n_fail++; $display("FAIL reset_status got %h want %h", q, 32'h1); end
    endtask

    task automatic test_ram();
        step(1'b1, 12'h010, 32'hDEADBEEF, 1'b1, 1'b0);
        step(1'b1, 12'h010, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rd got %h want %h", q, 32'hDEADBEEF); end
        step(1'b1, 12'h010, 32'h1, 1'b1, 1'b0);
        n_tests++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_rdw_old got %h want %h", q, 32'hDEADBEEF); end
        step(1'b1, 12'h010, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'h1) begin n_fail++; $display("FAIL ram_rdw_new got %h want %h", q, 32'h1); end
        // top RAM word boundary
        step(1'b1, 12'(RAM_DEPTH - 1), 32'h0BADF00D, 1'b1, 1'b0);
        step(1'b1, 12'(RAM_DEPTH - 1), 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'h0BADF00D) begin n_fail++; $display("FAIL ram_top got %h want %h", q, 32'h0BADF00D); end
    endtask

    task automatic test_led_unmapped();
        step(1'b1, 12'hFF1, 32'h0001A5A5, 1'b1, 1'b0);
        n_tests++; if (led_out !== 16'hA5A5) begin n_fail++; $display("FAIL led got %h want a5a5", led_out); end
        step(1'b1, 12'hFF1, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'h0000A5A5) begin n_fail++; $display("FAIL led_rd got %h want %h", q, 32'h0000A5A5); end
        step(1'b1, 12'h000, 32'hCAFEF00D, 1'b1, 1'b0);
        step(1'b1, 12'h800, 32'h12345678, 1'b1, 1'b0);
        step(1'b1, 12'h800, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'd0) begin n_fail++; $display("FAIL unmapped_rd got %h want 0", q); end
        step(1'b1, 12'h000, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'hCAFEF00D) begin n_fail++; $display("FAIL unmapped_alias got %h want %h", q, 32'hCAFEF00D); end
        step(1'b1, 12'(RAM_DEPTH), 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'd0) begin n_fail++; $display("FAIL ram_end_rd got %h want 0", q); end
        step(1'b1, 12'hFF2, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'd0) begin n_fail++; $display("FAIL push_rd got %h want 0", q); end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] want [5];
        want = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        step(1'b1, 12'hFF2, 32'(want[0]), 1'b1, 1'b0);
        // no bypass: valid only after the push edge, and head stays put
        n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL push_valid got %b/%h want 1/41", tx_valid, tx_data); end
        for (int i = 1; i < 5; i++) step(1'b1, 12'hFF2, 32'(want[i]), 1'b1, 1'b0);
        n_tests++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL head_hold got %h want 41", tx_data); end
        step(1'b1, 12'hFF3, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'h46) begin n_fail++; $display("FAIL ovf_status got %h want %h", q, 32'h46); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== want[i]) begin
                n_fail++; $display("FAIL drain%0d got %b/%h want 1/%h", i, tx_valid, tx_data, want[i]);
            end
            step(1'b1, 12'h000, 32'd0, 1'b0, 1'b1);
        end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", tx_valid); end
        step(1'b1, 12'hFF3, 32'h4, 1'b1, 1'b0);
        step(1'b1, 12'hFF3, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'h1) begin n_fail++; $display("FAIL ovf_clear got %h want %h", q, 32'h1); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] want [4];
        want = '{8'h62, 8'h63, 8'h64, 8'h55};
        for (int i = 0; i < 4; i++) step(1'b1, 12'hFF2, 32'h61 + 32'(i), 1'b1, 1'b0);
        step(1'b1, 12'hFF2, 32'h55, 1'b1, 1'b1);
        step(1'b1, 12'hFF3, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'h42) begin n_fail++; $display("FAIL fullpp_status got %h want %h", q, 32'h42); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== want[i]) begin
                n_fail++; $display("FAIL fullpp_drain%0d got %b/%h want 1/%h", i, tx_valid, tx_data, want[i]);
            end
            step(1'b1, 12'h000, 32'd0, 1'b0, 1'b1);
        end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL fullpp_empty got %b want 0", tx_valid); end
    endtask

    task automatic test_counter();
        logic [31:0] first;
        step(1'b1, 12'hFF0, 32'd0, 1'b0, 1'b0);
        first = q;
        for (int i = 0; i < 9; i++) step(1'b1, 12'h000, 32'd0, 1'b0, 1'b0);
        step(1'b1, 12'hFF0, 32'd0, 1'b0, 1'b0);
`ifdef MMIO_CYCLE_COUNTER_EN
        n_tests++; if (q - first !== 32'd10) begin n_fail++; $display("FAIL cyc_delta got %0d want 10", q - first); end
`else
        n_tests++; if (first !== 32'd0 || q !== 32'd0) begin n_fail++; $display("FAIL cyc_off got %h/%h want 0/0", first, q); end
`endif
        n_tests++; if (q !== exp_q) begin n_fail++; $display("FAIL cyc_model got %h want %h", q, exp_q); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 12'hFF2, 32'h90 + 32'(i), 1'b1, 1'b0);
        n_tests++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill got %b want 1", tx_valid); end
        step(1'b0, 12'hFF1, 32'hFFFF, 1'b1, 1'b1);
        n_tests++; if (tx_valid !== 1'b0 || led_out !== '0) begin n_fail++; $display("FAIL mid_reset got %b/%h want 0/0", tx_valid, led_out); end
        step(1'b1, 12'hFF3, 32'd0, 1'b0, 1'b0);
        n_tests++; if (q !== 32'h1) begin n_fail++; $display("FAIL mid_status got %h want %h", q, 32'h1); end
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [31:0] d;
        logic [11:0] ramset [17];
        for (int i = 0; i < 16; i++) ramset[i] = 12'(i);
        ramset[16] = 12'(RAM_DEPTH - 1);
        for (int i = 0; i < 17; i++) step(1'b1, ramset[i], $urandom, 1'b1, 1'b0);
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = ramset[$urandom_range(0, 16)];
                4: begin
                    case ($urandom_range(0, 2))
                        0: a = 12'(RAM_DEPTH);
                        1: a = 12'hFEF;
                        default: a = 12'h800;
                    endcase
                end
                5, 6: a = 12'hFF2;
                default: a = 12'($urandom_range(12'hFF0, 12'hFFF));
            endcase
            d = $urandom;
            step(($urandom_range(0, 99) != 0), a, d, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0);
            n_tests++; if (q !== exp_q) begin n_fail++; $display("FAIL rnd_q c%0d a=%h got %h want %h", c, a, q, exp_q); end
            n_tests++; if (led_out !== led_m) begin n_fail++; $display("FAIL rnd_led c%0d got %h want %h", c, led_out, led_m); end
            n_tests++; if (tx_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", c, tx_valid, exp_valid()); end
            n_tests++; if (tx_data !== exp_head()) begin n_fail++; $display("FAIL rnd_data c%0d got %h want %h", c, tx_data, exp_head()); end
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led_unmapped();
        test_fifo_overflow();
        test_full_push_pop();
        test_counter();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Responder end of the processor's dmem port. It accepts the 12-bit word address, 32-bit write data and write enable, and returns read data one clock later, matching syncram timing. The low address range is backed by a word RAM. The top of the map is a small memory-mapped I/O window: a cycle counter, an LED register, and a byte transmit FIFO drained over a valid/ready handshake. It replaces the bare dmem instance for bring-up and test programs.

Parameters:
RAM_DEPTH, 1024, number of 32-bit RAM words mapped at word address 0 to RAM_DEPTH-1; power of 2, maximum 2048.
FIFO_DEPTH, 4, transmit FIFO entries; power of 2, range 2 to 16.
LED_W, 16, width of the LED output register.

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
address  in  12  dmem word address from the processor
data  in  32  dmem write data
wren  in  1  dmem write enable
q  out  32  registered read data
led_out  out  LED_W  LED register contents
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  consumer accepts the head byte this cycle

Behaviour:
- Reset (reset==0 sampled at a rising edge) takes effect that edge:
  - q=0, led_out=0, FIFO emptied (tx_valid=0, tx_data=0), overflow=0, cycle counter=0.
  - RAM contents are not cleared.
  - Reset overrides any write, push or pop presented in the same cycle.
- Address map (word addresses):
  - 0x000 to RAM_DEPTH-1: RAM, read/write.
  - RAM_DEPTH to 0xFEF: unmapped; reads return 0, writes ignored.
  - 0xFF0: cycle counter, read-only.
  - 0xFF1: LED register; a write loads data[LED_W-1:0]; a read returns it zero-extended.
  - 0xFF2: TX push, write-only; a write pushes data[7:0]; a read returns 0.
  - 0xFF3: status. Read layout: bit0 empty, bit1 full, bit2 overflow, bits[8:4] count, other bits 0. A write with data[2]=1 clears overflow.
  - 0xFF4 to 0xFFF: unmapped.
- Read latency is exactly 1 cycle: q after edge N reflects the address sampled at edge N.
  - q updates every cycle, including cycles with wren=1.
  - A RAM write and read of the same address in one cycle returns the OLD word; the new value is visible on the next access.
  - A status read in the same cycle as a push or pop returns the pre-update values.
- RAM write: mem[address] <= data at the edge when wren=1 and the address is in RAM range.
- Cycle counter: 32-bit, +1 every non-reset edge, wraps 0xFFFFFFFF to 0.
- TX FIFO:
  - push = wren && address==0xFF2; pop = tx_valid && tx_ready.
  - tx_data is the head entry; it holds stable while tx_valid=1 and tx_ready=0.
  - No bypass: a push into an empty FIFO raises tx_valid on the following cycle.
  - Push when full and no pop: data dropped, overflow set (sticky), count unchanged.
  - Push and pop in the same cycle when full: both happen, count stays FIFO_DEPTH, overflow unchanged.
  - Push and pop in the same cycle otherwise: count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Count is FIFO_DEPTH+1 states (0 to FIFO_DEPTH) and is reported zero-extended in bits[8:4].
  - Overflow clear and overflow set in the same cycle: set wins.
- Mid-operation reset discards queued bytes; tx_valid drops on the reset edge regardless of tx_ready.

Optional Feature:
MMIO_CYCLE_COUNTER_EN
- Defined: the 32-bit counter is implemented and readable at 0xFF0 as above.
- Undefined: no counter flops are built; 0xFF0 reads 0 and behaves as unmapped.

Test Plan:
- Reset low one edge, then high: q=0, led_out=0, tx_valid=0, status read at 0xFF3 returns 0x00000001.
- Write 0xDEADBEEF to 0x010, then read 0x010: q=0xDEADBEEF exactly one cycle after the read address. A same-cycle write of 0x1 with read of 0x010 returns 0xDEADBEEF; the next read returns 0x1.
- Write 0x0001A5A5 to 0xFF1: led_out=0xA5A5. A read of 0x800 returns 0; a write to 0x800 leaves RAM unchanged.
- With tx_ready=0, push 0x41,0x42,0x43,0x44,0x45: status reads full=1, count=4, overflow=1. Raise tx_ready: tx_data sequence is 0x41 to 0x44, then tx_valid=0. Write 0x4 to 0xFF3: overflow=0.
- Full FIFO with tx_ready=1 and a push of 0x55 in the same cycle: count stays 4, overflow stays 0, 0x55 is emitted last.
- With MMIO_CYCLE_COUNTER_EN defined, reads of 0xFF0 ten cycles apart differ by 10. Undefined: reads of 0xFF0 return 0. Reset asserted mid-stream with 3 bytes queued: tx_valid=0 on the next cycle.
